// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM frame sequencer.
package ppm_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int CHAN_W       = 3;
  localparam int TIME_W       = 8;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Saturating increment for the tick interval counter.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ppm_frame_sequencer_if.sv
// Output bundle of the PPM frame sequencer: channel strobes and frame status.
interface ppm_frame_sequencer_if;
  import ppm_pkg::*;

  logic              store_time;
  logic [CHAN_W-1:0] channel;
  logic [TIME_W-1:0] diff_time;
  logic              frame_valid;
  logic              frame_error;
  logic              locked;

  modport master (
    output store_time, channel, diff_time, frame_valid, frame_error, locked
  );

  modport slave (
    input store_time, channel, diff_time, frame_valid, frame_error, locked
  );
endinterface

// File: rtl/ppm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PPM line plus rising-edge detect.
module ppm_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Metastability filter followed by a one-cycle history flop for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/ppm_frame_sequencer.sv
// PPM frame sequencer: measures intervals between rising edges in ticks and
// reports eight channel intervals per frame, delimited by long sync gaps.
module ppm_frame_sequencer
  import ppm_pkg::*;
#(
  parameter int TICK_CYCLES = 500,
  parameter int SYNC_TICKS  = 250,
  parameter int MIN_TICKS   = 70
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ppm_signal,
  ppm_frame_sequencer_if.master        seq
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [TIME_W-1:0] SYNC_T   = TIME_W'(SYNC_TICKS);
  localparam logic [TIME_W-1:0] MIN_T    = TIME_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_CHANNELS);

  logic              rise;
  logic              tick;
  logic              gap;
  logic [PRE_W-1:0]  presc;
  logic [TIME_W-1:0] interval;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              store_nxt;
  logic              fv_nxt;
  logic              fe_nxt;
  logic [CHAN_W-1:0] chan_nxt;
  logic [TIME_W-1:0] diff_nxt;

  ppm_edge_sync u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (ppm_signal),
    .rise     (rise)
  );

  assign tick = (presc == PRE_LAST);
  assign gap  = (interval >= SYNC_T);

  // Prescaler and interval counter; an edge restarts both and beats a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= '0;
      interval <= '0;
    end else if (rise) begin
      presc    <= '0;
      interval <= '0;
    end else if (tick) begin
      presc    <= '0;
      interval <= sat_inc(interval);
    end else begin
      presc    <= presc + 1'b1;
    end
  end

  // State, channel count and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= HUNT;
      count           <= '0;
      seq.store_time  <= 1'b0;
      seq.frame_valid <= 1'b0;
      seq.frame_error <= 1'b0;
      seq.channel     <= '0;
      seq.diff_time   <= '0;
    end else begin
      state           <= state_nxt;
      count           <= count_nxt;
      seq.store_time  <= store_nxt;
      seq.frame_valid <= fv_nxt;
      seq.frame_error <= fe_nxt;
      seq.channel     <= chan_nxt;
      seq.diff_time   <= diff_nxt;
    end
  end

  // Next-state and strobe decode. A gap seen together with an edge counts as
  // the gap, so the frame boundary is never missed.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    store_nxt = 1'b0;
    fv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    chan_nxt  = seq.channel;
    diff_nxt  = seq.diff_time;
    unique case (state)
      HUNT: begin
        if (gap) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          state_nxt = CAPTURE;
          count_nxt = '0;
        end
      end
      CAPTURE: begin
        if (gap) begin
          if (count == FULL_CNT) fv_nxt = 1'b1;
          else                   fe_nxt = 1'b1;
          state_nxt = ARMED;
          count_nxt = '0;
        end else if (rise) begin
          if ((interval < MIN_T) || (count == FULL_CNT)) begin
            fe_nxt    = 1'b1;
            state_nxt = HUNT;
            count_nxt = '0;
          end else begin
            store_nxt = 1'b1;
            chan_nxt  = count[CHAN_W-1:0];
            diff_nxt  = interval;
            count_nxt = count + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = HUNT;
        count_nxt = '0;
      end
    endcase
  end

  assign seq.locked = (state != HUNT);

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed testbench for ppm_frame_sequencer (TICK_CYCLES=4, SYNC_TICKS=50,
// MIN_TICKS=10). An interval of N ticks is produced by spacing input edges
// N*4+2 clock cycles apart, which places each edge mid-tick.
module tb_ppm_frame_sequencer;

  localparam int TICK  = 4;
  localparam int GAP_C = 60 * TICK;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ppm_signal = 1'b0;

  ppm_frame_sequencer_if bus ();

  ppm_frame_sequencer #(
    .TICK_CYCLES (4),
    .SYNC_TICKS  (50),
    .MIN_TICKS   (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ppm_signal (ppm_signal),
    .seq        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int edge_cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int fv_n = 0;
  int fe_n = 0;
  int clash_n = 0;
  int ch_q[$];
  int dt_q[$];
  int lat_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe and frame pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.store_time) begin
      ch_q.push_back(int'(bus.channel));
      dt_q.push_back(int'(bus.diff_time));
      lat_q.push_back(cyc - edge_cyc);
    end
    if (bus.frame_valid) fv_n++;
    if (bus.frame_error) fe_n++;
    if ((bus.store_time & bus.frame_valid) | (bus.store_time & bus.frame_error) |
        (bus.frame_valid & bus.frame_error)) clash_n++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rising edge on the line, then wait so the next edge lands gap_cycles later.
  task automatic send_edge(input int gap_cycles);
    @(posedge clk);
    #1 ppm_signal = 1'b1;
    edge_cyc = cyc;
    repeat (2) @(posedge clk);
    #1 ppm_signal = 1'b0;
    repeat (gap_cycles - 3) @(posedge clk);
  endtask

  // Start edge plus n intervals of base+i*step ticks, then tail cycles idle.
  task automatic frame(input int n, input int base, input int step, input int tail);
    for (int i = 0; i < n; i++) send_edge((base + i * step) * TICK + 2);
    send_edge(tail);
  endtask

  task automatic check_strobes(input string tag, input int first, input int n,
                               input int base, input int step);
    check({tag, "_count"}, ch_q.size() - first, n);
    for (int i = 0; i < n; i++) begin
      if (first + i < ch_q.size()) begin
        check($sformatf("%s_ch%0d", tag, i), ch_q[first + i], i);
        check($sformatf("%s_dt%0d", tag, i), dt_q[first + i], base + i * step);
      end
    end
  endtask

  int s0, fv0, fe0;

  initial begin
    // Reset state
    #2;
    check("rst_store", int'(bus.store_time), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_fv", int'(bus.frame_valid), 0);
    check("rst_fe", int'(bus.frame_error), 0);
    check("rst_chan", int'(bus.channel), 0);
    check("rst_diff", int'(bus.diff_time), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Long idle in HUNT: ARMED at 50 ticks, interval saturates at 255
    repeat (48 * TICK) @(posedge clk);
    #1 check("hunt_before_50", int'(bus.locked), 0);
    repeat (4 * TICK) @(posedge clk);
    #1 check("armed_after_50", int'(bus.locked), 1);
    repeat (248 * TICK) @(posedge clk);
    #1 check("interval_sat", int'(dut.interval), 255);

    // Full frame 20..27 ticks
    s0 = ch_q.size(); fv0 = fv_n; fe0 = fe_n;
    frame(8, 20, 1, GAP_C);
    check_strobes("frame1", s0, 8, 20, 1);
    if (s0 < lat_q.size()) check("latency", lat_q[s0], 3);
    check("frame1_fv", fv_n - fv0, 1);
    check("frame1_fe", fe_n - fe0, 0);

    // Short frame of 5 channels, then a full frame
    s0 = ch_q.size(); fv0 = fv_n; fe0 = fe_n;
    frame(5, 30, 0, GAP_C);
    check_strobes("short", s0, 5, 30, 0);
    check("short_fe", fe_n - fe0, 1);
    check("short_fv", fv_n - fv0, 0);
    check("short_locked", int'(bus.locked), 1);
    s0 = ch_q.size(); fv0 = fv_n;
    frame(8, 22, 2, GAP_C);
    check_strobes("after_short", s0, 8, 22, 2);
    check("after_short_fv", fv_n - fv0, 1);

    // Runt interval of 5 ticks
    s0 = ch_q.size(); fe0 = fe_n;
    send_edge(30 * TICK + 2);
    send_edge(5 * TICK + 2);
    send_edge(30 * TICK + 2);
    check("runt_fe", fe_n - fe0, 1);
    check("runt_locked", int'(bus.locked), 0);
    for (int i = 0; i < 3; i++) send_edge(30 * TICK + 2);
    check("runt_strobes", ch_q.size() - s0, 1);
    check("runt_still_hunt", int'(bus.locked), 0);
    repeat (GAP_C) @(posedge clk);
    #1 check("runt_rearmed", int'(bus.locked), 1);

    // Nine intervals: ninth edge is an error
    s0 = ch_q.size(); fe0 = fe_n; fv0 = fv_n;
    frame(9, 30, 0, 20);
    check_strobes("nine", s0, 8, 30, 0);
    check("nine_fe", fe_n - fe0, 1);
    check("nine_hunt", int'(bus.locked), 0);
    repeat (GAP_C) @(posedge clk);
    check("nine_fv", fv_n - fv0, 0);

    // Reset mid-frame after channel 3
    s0 = ch_q.size();
    for (int i = 0; i < 5; i++) send_edge(30 * TICK + 2);
    check("pre_rst_strobes", ch_q.size() - s0, 4);
    check("pre_rst_chan", int'(bus.channel), 3);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_chan", int'(bus.channel), 0);
    check("mid_rst_diff", int'(bus.diff_time), 0);
    check("mid_rst_locked", int'(bus.locked), 0);
    check("mid_rst_store", int'(bus.store_time), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    s0 = ch_q.size();
    for (int i = 0; i < 4; i++) send_edge(30 * TICK + 2);
    check("post_rst_strobes", ch_q.size() - s0, 0);
    check("post_rst_locked", int'(bus.locked), 0);
    repeat (GAP_C) @(posedge clk);
    s0 = ch_q.size(); fv0 = fv_n;
    frame(8, 40, 1, GAP_C);
    check_strobes("post_rst_frame", s0, 8, 40, 1);
    check("post_rst_fv", fv_n - fv0, 1);

    check("no_clash", clash_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time bound
  initial begin
    #3000000;
    $display("FAIL timeout: got %0d, expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ppm_frame_sequencer.md
PPM_FRAME_SEQUENCER -- requirements
Module: ppm_frame_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_CYCLES, default 500, meaning clk cycles per time tick (10 us at 50 MHz).
REQ-002 The block SHALL have parameter SYNC_TICKS, default 250, meaning the minimum interval in ticks recognised as a frame sync gap.
REQ-003 The block SHALL have parameter MIN_TICKS, default 70, meaning the minimum legal channel interval in ticks.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ppm_signal, input, 1 bit: raw receiver PPM line, asynchronous to clk.
REQ-007 The block SHALL have port store_time, output, 1 bit: one-cycle strobe that diff_time is valid for channel.
REQ-008 The block SHALL have port channel, output, 3 bits: index of the channel being stored.
REQ-009 The block SHALL have port diff_time, output, 8 bits: measured channel interval in ticks.
REQ-010 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a complete 8-channel frame ends.
REQ-011 The block SHALL have port frame_error, output, 1 bit: one-cycle pulse when a malformed frame is detected.
REQ-012 The block SHALL have port locked, output, 1 bit: high whenever the FSM is not in HUNT.

Function
REQ-013 ppm_signal SHALL pass a 2-flop synchronizer; a rising edge is sync2 high with the previous sync2 low; store_time rises exactly 3 clk cycles after the input edge.
REQ-014 Prescaler SHALL count 0..TICK_CYCLES-1 and emit a one-cycle tick on wrap.
REQ-015 Interval counter (8 bits) SHALL increment on tick and saturate at 255.
REQ-016 On every detected rising edge, prescaler and interval counter SHALL clear in the same cycle; an edge coinciding with a tick wins, giving interval 0.
REQ-017 FSM states SHALL be HUNT, ARMED, CAPTURE, plus a 4-bit stored-channel count (0..8).
REQ-018 HUNT: edges are ignored apart from clearing the counter; when interval reaches SYNC_TICKS, the FSM SHALL go to ARMED.
REQ-019 ARMED: a rising edge SHALL go to CAPTURE with count=0 and no strobe; the edge marks the start of channel 0.
REQ-020 CAPTURE, edge with interval < MIN_TICKS: pulse frame_error and go to HUNT, with no strobe.
REQ-021 CAPTURE, edge with MIN_TICKS <= interval < SYNC_TICKS and count < 8: pulse store_time, set diff_time=interval and channel=count[2:0], then increment count.
REQ-022 CAPTURE, edge with count == 8 (ninth interval): pulse frame_error and go to HUNT, with no strobe.
REQ-023 CAPTURE, interval reaching SYNC_TICKS with no edge: if count == 8, pulse frame_valid, otherwise pulse frame_error; in both cases go to ARMED.
REQ-024 channel and diff_time SHALL hold their values between strobes.
REQ-025 frame_valid and frame_error SHALL never assert in the same cycle, and neither SHALL assert in the same cycle as store_time.

Reset
REQ-026 Asserting reset_n low SHALL asynchronously force: state HUNT, count 0, prescaler 0, interval 0, synchronizer flops 0, and all outputs 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the FSM SHALL require a fresh sync gap before any store_time.

Structure
REQ-028 Package ppm_pkg SHALL hold the state enum, NUM_CHANNELS=8, CHAN_W=3 and TIME_W=8.
REQ-029 The synchronizer and edge detector SHALL be sub-module ppm_edge_sync (clk, reset_n, async_in, rise).

Verification (TICK_CYCLES=4, SYNC_TICKS=50, MIN_TICKS=10)
REQ-030 Sync gap, then edges 20,21,...,27 ticks apart, then gap: 8 strobes on channels 0..7 with diff_time 20..27, then frame_valid once.
REQ-031 Sync gap, 5 channel intervals of 30, then gap: 5 strobes, then frame_error; locked stays 1 and the next full frame yields frame_valid.
REQ-032 In CAPTURE, an edge 5 ticks after the previous one: frame_error, locked=0, no strobe until a new gap and edge.
REQ-033 Nine intervals of 30 ticks: 8 strobes, then frame_error at the ninth edge, and the FSM is in HUNT.
REQ-034 Line held low for 300 ticks in HUNT: interval saturates at 255 and ARMED is entered at tick 50.
REQ-035 reset_n pulsed low after channel 3: all outputs read 0 immediately; the following intervals produce no strobe until a gap plus edge.
